// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stage indices, hold/bubble masks
// and the trap FSM state encoding.
package pipe_ctrl_pkg;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // Stage index map of the stalled/flush vectors.
   localparam int STG_PC     = 0;
   localparam int STG_IF_ID  = STG_PC + 1;
   localparam int STG_ID_EX  = STG_PC + 2;
   localparam int STG_EX_MEM = STG_PC + 3;
   localparam int STG_MEM_WB = STG_PC + 4;
   localparam int STG_WB     = STG_PC + 5;

   typedef enum logic [1:0] {
      PIPE_RUN   = 2'd0,
      PIPE_DRAIN = 2'd1,
      PIPE_FLUSH = 2'd2
   } pipe_state_e;

   // Mask with every stage index strictly below n set.
   function automatic logic [5:0] below(input int n);
      logic [5:0] m;
      for (int i = 0; i < 6; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

   localparam logic [5:0] STALL_MEM    = below(STG_WB);
   localparam logic [5:0] STALL_EX     = below(STG_MEM_WB);
   localparam logic [5:0] STALL_ID     = below(STG_EX_MEM);
   localparam logic [5:0] STALL_IF     = below(STG_ID_EX);
   localparam logic [5:0] FLUSH_BRANCH = below(STG_EX_MEM) & ~below(STG_IF_ID);
   localparam logic [5:0] FLUSH_TRAP   = below(STG_WB) & ~below(STG_IF_ID);

   // The most downstream requester decides how far back the hold reaches.
   function automatic logic [5:0] stall_prio(input logic mem, input logic ex,
                                             input logic id, input logic fe);
      if (mem)     return STALL_MEM;
      else if (ex) return STALL_EX;
      else if (id) return STALL_ID;
      else if (fe) return STALL_IF;
      return 6'b000000;
   endfunction

endpackage

// File: rtl/pipe_ctrl_wdt.sv
// Stall watchdog: counts consecutive stalled cycles and pulses at WDT_LIMIT.
// Only compiled when PIPE_CTRL_WDT_EN is defined.
`ifdef PIPE_CTRL_WDT_EN
module pipe_ctrl_wdt #(
   parameter int WDT_LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic i_stall_any,
   output logic o_pulse
);

   localparam logic [15:0] LAST = 16'(WDT_LIMIT - 1);

   logic [15:0] r_scnt;

   assign o_pulse = i_stall_any && (r_scnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scnt <= '0;
      end else if (!i_stall_any || o_pulse) begin
         r_scnt <= '0;
      end else if (r_scnt != 16'hFFFF) begin
         r_scnt <= r_scnt + 16'd1;
      end
   end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: stall/flush vectors, branch and trap redirects.
// Optional stall watchdog enabled by defining PIPE_CTRL_WDT_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int WDT_LIMIT    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if_i,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        stallreq_mem_i,
   input  logic        ex_branch_flag_i,
   input  logic [31:0] ex_branch_addr_i,
   input  logic        excp_req_i,
   input  logic [31:0] excp_vec_i,
   output logic        excp_ack_o,
   output logic [5:0]  stalled_o,
   output logic [5:0]  flush_o,
   output logic [31:0] new_pc_o,
   output logic        new_pc_valid_o,
   output logic        wdt_timeout_o
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
      $error("pipe_ctrl: FLUSH_CYCLES must be 1..15");
   end
   if (WDT_LIMIT < 1 || WDT_LIMIT > 65536) begin : g_bad_wdt
      $error("pipe_ctrl: WDT_LIMIT must be 1..65536");
   end

   localparam logic [3:0] FCNT_LAST = 4'(FLUSH_CYCLES - 1);

   pipe_state_e r_state;
   logic [3:0]  r_fcnt;
   logic [31:0] r_vec_q;
   logic        r_rst_dly;

   logic        w_br_req;
   logic        w_trap;
   logic        w_wdt_pulse;
   logic        w_ack;
   logic [5:0]  w_stalled;
   logic [5:0]  w_flush;
   logic [31:0] w_new_pc;
   logic        w_new_pc_valid;

   // A taken branch is only honoured when EX itself is not frozen.
   assign w_br_req = ex_branch_flag_i && !stallreq_ex_i && !stallreq_mem_i;

   // Kept separate from the trap decode: the watchdog observes stalled_o and
   // feeds the trap request, so the hold vector must not depend on the trap.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_stalled = '0;
      if (!r_rst_dly) begin
         unique case (r_state)
            PIPE_RUN:   w_stalled = stall_prio(stallreq_mem_i, stallreq_ex_i,
                                               stallreq_id_i && !w_br_req,
                                               stallreq_if_i && !w_br_req);
            PIPE_DRAIN: w_stalled = stall_prio(stallreq_mem_i, stallreq_ex_i,
                                               stallreq_id_i, stallreq_if_i);
            default:    w_stalled = '0;
         endcase
      end
   end

`ifdef PIPE_CTRL_WDT_EN
   pipe_ctrl_wdt #(
      .WDT_LIMIT (WDT_LIMIT)
   ) u_wdt (
      .clk         (clk),
      .rst         (rst),
      .i_stall_any (|w_stalled),
      .o_pulse     (w_wdt_pulse)
   );
`else
   assign w_wdt_pulse = 1'b0;
`endif

   assign w_trap = excp_req_i || w_wdt_pulse;

   always_comb begin
      w_ack          = 1'b0;
      w_flush        = '0;
      w_new_pc       = ZERO_WORD;
      w_new_pc_valid = 1'b0;
      if (!r_rst_dly) begin
         unique case (r_state)
            PIPE_RUN: begin
               if (w_trap) begin
                  w_ack = !stallreq_mem_i;
               end else if (w_br_req) begin
                  w_flush        = FLUSH_BRANCH;
                  w_new_pc       = ex_branch_addr_i;
                  w_new_pc_valid = 1'b1;
               end
            end
            PIPE_DRAIN: begin
               w_ack = !stallreq_mem_i;
            end
            PIPE_FLUSH: begin
               w_flush = FLUSH_TRAP;
               if (r_fcnt == 4'd0) begin
                  w_new_pc       = r_vec_q;
                  w_new_pc_valid = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign excp_ack_o     = w_ack;
   assign stalled_o      = w_stalled;
   assign flush_o        = w_flush;
   assign new_pc_o       = w_new_pc;
   assign new_pc_valid_o = w_new_pc_valid;
   assign wdt_timeout_o  = w_wdt_pulse;

   // r_rst_dly keeps the block silent for the first cycle after reset release.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         r_state   <= PIPE_RUN;
         r_fcnt    <= '0;
         r_vec_q   <= ZERO_WORD;
         r_rst_dly <= 1'b1;
      end else begin
         r_rst_dly <= 1'b0;
         if (!r_rst_dly) begin
            unique case (r_state)
               PIPE_RUN: begin
                  if (w_trap) begin
                     if (stallreq_mem_i) begin
                        r_state <= PIPE_DRAIN;
                     end else begin
                        r_state <= PIPE_FLUSH;
                        r_vec_q <= excp_vec_i;
                     end
                  end
               end
               PIPE_DRAIN: begin
                  if (!stallreq_mem_i) begin
                     r_state <= PIPE_FLUSH;
                     r_vec_q <= excp_vec_i;
                  end
               end
               PIPE_FLUSH: begin
                  if (r_fcnt == FCNT_LAST) begin
                     r_state <= PIPE_RUN;
                     r_fcnt  <= '0;
                  end else begin
                     r_fcnt <= r_fcnt + 4'd1;
                  end
               end
               default: r_state <= PIPE_RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (FLUSH_CYCLES=2, WDT_LIMIT=8).
// The watchdog scenario runs only when PIPE_CTRL_WDT_EN is defined.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq_if_i = 1'b0;
   logic        stallreq_id_i = 1'b0;
   logic        stallreq_ex_i = 1'b0;
   logic        stallreq_mem_i = 1'b0;
   logic        ex_branch_flag_i = 1'b0;
   logic [31:0] ex_branch_addr_i = '0;
   logic        excp_req_i = 1'b0;
   logic [31:0] excp_vec_i = '0;
   logic        excp_ack_o;
   logic [5:0]  stalled_o;
   logic [5:0]  flush_o;
   logic [31:0] new_pc_o;
   logic        new_pc_valid_o;
   logic        wdt_timeout_o;

   int n_cmp = 0;
   int n_err = 0;

   pipe_ctrl #(
      .FLUSH_CYCLES (2),
      .WDT_LIMIT    (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stallreq_if_i    (stallreq_if_i),
      .stallreq_id_i    (stallreq_id_i),
      .stallreq_ex_i    (stallreq_ex_i),
      .stallreq_mem_i   (stallreq_mem_i),
      .ex_branch_flag_i (ex_branch_flag_i),
      .ex_branch_addr_i (ex_branch_addr_i),
      .excp_req_i       (excp_req_i),
      .excp_vec_i       (excp_vec_i),
      .excp_ack_o       (excp_ack_o),
      .stalled_o        (stalled_o),
      .flush_o          (flush_o),
      .new_pc_o         (new_pc_o),
      .new_pc_valid_o   (new_pc_valid_o),
      .wdt_timeout_o    (wdt_timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge, apply inputs, let combinational paths settle.
   task automatic cyc(input logic fe, input logic id, input logic ex, input logic mem,
                      input logic br, input logic [31:0] baddr,
                      input logic exc, input logic [31:0] evec);
      @(negedge clk);
      stallreq_if_i    = fe;
      stallreq_id_i    = id;
      stallreq_ex_i    = ex;
      stallreq_mem_i   = mem;
      ex_branch_flag_i = br;
      ex_branch_addr_i = baddr;
      excp_req_i       = exc;
      excp_vec_i       = evec;
      #2;
   endtask

   task automatic expect_out(input string tag, input logic [5:0] st, input logic [5:0] fl,
                             input logic v, input logic [31:0] pc, input logic ack);
      chk({tag, ".stalled"}, {26'd0, stalled_o}, {26'd0, st});
      chk({tag, ".flush"},   {26'd0, flush_o},   {26'd0, fl});
      chk({tag, ".valid"},   {31'd0, new_pc_valid_o}, {31'd0, v});
      chk({tag, ".new_pc"},  new_pc_o, pc);
      chk({tag, ".ack"},     {31'd0, excp_ack_o}, {31'd0, ack});
   endtask

   initial begin
      // Reset held: everything quiet.
      #2;
      expect_out("rst_hold", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);

      // Cycle after release is still silent even with a stall request present.
      @(negedge clk);
      rst           = 1'b0;
      stallreq_id_i = 1'b1;
      #2;
      expect_out("rst_after", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);

      // 1: decode stall for 3 cycles, then released.
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
         expect_out($sformatf("id_stall%0d", i), 6'b000111, 6'b0, 1'b0, 32'h0, 1'b0);
      end
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      expect_out("id_release", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);

      // 2: priority of stall requests.
      cyc(1, 0, 0, 1, 0, 32'h0, 0, 32'h0);
      expect_out("if_mem", 6'b011111, 6'b0, 1'b0, 32'h0, 1'b0);
      cyc(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);
      expect_out("ex_prio", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b0);
      cyc(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      expect_out("if_only", 6'b000011, 6'b0, 1'b0, 32'h0, 1'b0);

      // 3: branch redirect, branch masking id stall, branch held off by ex stall.
      cyc(0, 0, 0, 0, 1, 32'h80, 0, 32'h0);
      expect_out("branch", 6'b0, 6'b000110, 1'b1, 32'h80, 1'b0);
      cyc(1, 1, 0, 0, 1, 32'h84, 0, 32'h0);
      expect_out("br_id", 6'b0, 6'b000110, 1'b1, 32'h84, 1'b0);
      cyc(0, 0, 1, 0, 1, 32'h88, 0, 32'h0);
      expect_out("br_ex", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b0);

      // 4: trap during mem stall drains, then flushes to 0x100.
      cyc(0, 0, 0, 1, 0, 32'h0, 1, 32'h100);
      expect_out("drain_a", 6'b011111, 6'b0, 1'b0, 32'h0, 1'b0);
      cyc(0, 0, 0, 1, 1, 32'h90, 1, 32'h100);
      expect_out("drain_b", 6'b011111, 6'b0, 1'b0, 32'h0, 1'b0);
      cyc(0, 0, 0, 0, 1, 32'h90, 1, 32'h100);
      expect_out("drain_ack", 6'b0, 6'b0, 1'b0, 32'h0, 1'b1);
      cyc(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
      expect_out("flush0", 6'b0, 6'b011110, 1'b1, 32'h100, 1'b0);
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      expect_out("flush1", 6'b0, 6'b011110, 1'b0, 32'h0, 1'b0);
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      expect_out("run_back", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);

      // 5: trap and branch together; trap held through FLUSH is re-acked in RUN.
      cyc(0, 0, 0, 0, 1, 32'h300, 1, 32'h200);
      expect_out("trap_br", 6'b0, 6'b0, 1'b0, 32'h0, 1'b1);
      cyc(0, 0, 0, 0, 0, 32'h0, 1, 32'h200);
      expect_out("tb_flush0", 6'b0, 6'b011110, 1'b1, 32'h200, 1'b0);
      cyc(0, 0, 0, 0, 0, 32'h0, 1, 32'h240);
      expect_out("tb_flush1", 6'b0, 6'b011110, 1'b0, 32'h0, 1'b0);
      cyc(0, 0, 0, 0, 0, 32'h0, 1, 32'h240);
      expect_out("tb_reack", 6'b0, 6'b0, 1'b0, 32'h0, 1'b1);
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      expect_out("tb_reflush", 6'b0, 6'b011110, 1'b1, 32'h240, 1'b0);
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      expect_out("tb_run", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);

      // 6: reset asserted during FLUSH.
      cyc(0, 0, 0, 0, 0, 32'h0, 1, 32'h400);
      expect_out("r6_ack", 6'b0, 6'b0, 1'b0, 32'h0, 1'b1);
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      expect_out("r6_flush0", 6'b0, 6'b011110, 1'b1, 32'h400, 1'b0);
      #1 rst = 1'b1;
      #1;
      expect_out("r6_async", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      expect_out("r6_after", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      expect_out("r6_run", 6'b0, 6'b0, 1'b0, 32'h0, 1'b0);
      chk("r6_wdt_idle", {31'd0, wdt_timeout_o}, 32'd0);

`ifdef PIPE_CTRL_WDT_EN
      // 7: ex stall stuck high; watchdog fires on the 8th stalled cycle.
      for (int i = 1; i <= 7; i++) begin
         cyc(0, 0, 1, 0, 0, 32'h0, 0, 32'h500);
         chk($sformatf("wdt_quiet%0d", i), {31'd0, wdt_timeout_o}, 32'd0);
      end
      cyc(0, 0, 1, 0, 0, 32'h0, 0, 32'h500);
      chk("wdt_pulse", {31'd0, wdt_timeout_o}, 32'd1);
      expect_out("wdt_ack", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b1);
      cyc(0, 0, 1, 0, 0, 32'h0, 0, 32'h500);
      expect_out("wdt_flush0", 6'b0, 6'b011110, 1'b1, 32'h500, 1'b0);
      chk("wdt_once", {31'd0, wdt_timeout_o}, 32'd0);
      cyc(0, 0, 1, 0, 0, 32'h0, 0, 32'h500);
      expect_out("wdt_flush1", 6'b0, 6'b011110, 1'b0, 32'h0, 1'b0);
      cyc(0, 0, 1, 0, 0, 32'h0, 0, 32'h500);
      expect_out("wdt_run", 6'b001111, 6'b0, 1'b0, 32'h0, 1'b0);
      chk("wdt_restart", {31'd0, wdt_timeout_o}, 32'd0);
      cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
